prog_sender: RTL and testbench

PROG_SENDER -- requirements
Module: prog_sender

---
 rtl/prog_sender.sv | 202 ++++++++++++++++++++
 tb/tb_prog_sender.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sender.sv
// rtl/prog_sender.sv - streams a zero-terminated program from word memory to a UART, big-endian
//
// Sends SYNC_BYTE, then reads 32-bit words from address 0 upward and sends each
// as four bytes MSB first. A zero word is sent as the terminator and ends the
// transfer. Running off the top of the address space without a terminator ends
// the transfer with err set.
//
// Optional feature macro: PROG_SENDER_WDOG_EN (transmitter handshake watchdog).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   start      in   one-cycle request to send one program (honoured only when idle)
//   rd_addr    out  word address to program memory
//   rd_data    in   program word, valid one cycle after rd_addr changes
//   tx_data    out  byte to the UART transmitter
//   tx_start   out  one-cycle send strobe to the UART transmitter
//   tx_busy    in   UART transmitter busy
//   busy       out  transfer in progress
//   done       out  one-cycle pulse at end of transfer
//   err        out  sticky overflow/watchdog flag, cleared by the next accepted start
//   word_count out  words fully sent in the current/last transfer

module prog_sender #(
  parameter int          ADDR_W      = 8,
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int          WDOG_CYCLES = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE, SYNC, FETCH, LATCH, ISSUE, WAIT_HI, WAIT_LO, DONE
  } state_e;

  // A watchdog limit below one cycle cannot be meaningful.
  if (WDOG_CYCLES < 1) begin : g_bad_wdog_cycles
    $error("prog_sender: WDOG_CYCLES must be at least 1");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic                sync_q, sync_d;       // the byte in flight is the sync byte
  logic [7:0]          tx_data_q, tx_data_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [1:0]          byte_idx_nxt;
  logic                wdog_expire;

  assign byte_idx_nxt = byte_idx_q + 2'd1;

`ifdef PROG_SENDER_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Counter is zero on the first cycle of a wait state, so the limit is hit on
  // the WDOG_CYCLES-th cycle spent waiting.
  assign wdog_expire = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = '0;
    if (state_d == state_q && (state_q == WAIT_HI || state_q == WAIT_LO)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    sync_d       = sync_q;
    tx_data_d    = tx_data_q;
    err_d        = err_q;
    word_count_d = word_count_q;
    tx_start     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SYNC;
          err_d        = 1'b0;
          word_count_d = '0;
          rd_addr_d    = '0;
        end
      end
      SYNC: begin
        tx_data_d = SYNC_BYTE;
        sync_d    = 1'b1;
        state_d   = ISSUE;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        word_d     = rd_data;
        byte_idx_d = 2'd0;
        tx_data_d  = rd_data[31:24];
        state_d    = ISSUE;
      end
      ISSUE: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (wdog_expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (sync_q) begin
            sync_d  = 1'b0;
            state_d = FETCH;
          end else if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_nxt;
            case (byte_idx_nxt)
              2'd1:    tx_data_d = word_q[23:16];
              2'd2:    tx_data_d = word_q[15:8];
              default: tx_data_d = word_q[7:0];
            endcase
            state_d = ISSUE;
          end else begin
            word_count_d = word_count_q + (ADDR_W+1)'(1);
            if (word_q == 32'd0) begin
              state_d = DONE;
            end else if (rd_addr_q == {ADDR_W{1'b1}}) begin
              // No terminator fits in the address space.
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              rd_addr_d = rd_addr_q + ADDR_W'(1);
              state_d   = FETCH;
            end
          end
        end else if (wdog_expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      word_q       <= '0;
      byte_idx_q   <= '0;
      sync_q       <= 1'b0;
      tx_data_q    <= '0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      sync_q       <= sync_d;
      tx_data_q    <= tx_data_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign tx_data    = tx_data_q;
  assign err        = err_q;
  assign word_count = word_count_q;
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_prog_sender.sv
// tb/tb_prog_sender.sv - directed self-checking bench for prog_sender
module tb_prog_sender;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  word_count;

  prog_sender #(.ADDR_W(2), .SYNC_BYTE(8'hAA), .WDOG_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy),
    .done(done), .err(err), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [4];
  always @(posedge clk) rd_data <= mem[rd_addr];

  logic       force_busy, stuck0;
  logic       ubusy = 1'b0;
  int         ucnt = 0;
  logic [7:0] cur = 8'h00;
  logic [7:0] bytes[$];
  int         nstart = 0, ndone = 0, stab_err = 0, wrap = 0;
  bit         seen = 0;

  assign tx_busy = ubusy | force_busy;

  // UART model: busy rises the cycle after tx_start and stays high 20 cycles.
  always @(posedge clk) begin
    if (done) ndone++;
    if (ubusy && tx_data !== cur) stab_err++;
    if (!busy) seen = 0;
    else if (rd_addr != 2'd0) seen = 1;
    else if (seen) wrap++;
    if (tx_start) begin
      bytes.push_back(tx_data);
      nstart++;
      cur <= tx_data;
      if (!stuck0) begin
        ubusy <= 1'b1;
        ucnt  <= 20;
      end
    end else if (ubusy) begin
      if (ucnt <= 1) ubusy <= 1'b0;
      ucnt <= ucnt - 1;
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int limit, input int period, output bit ok);
    ok = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (done) begin
        ok = 1;
        break;
      end
      start = (period != 0 && (i % period) == 0);
    end
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tx_start"}, tx_start, 1'b0);
    check({pfx, "_tx_data"}, tx_data, 8'h00);
    check({pfx, "_rd_addr"}, rd_addr, 2'd0);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_err"}, err, 1'b0);
    check({pfx, "_word_count"}, word_count, 3'd0);
  endtask

  function automatic logic [7:0] getb(input int base, input int i);
    if (base + i < bytes.size()) return bytes[base + i];
    return 8'hxx;
  endfunction

  logic [7:0] exp_a [9] = '{8'hAA, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_c [5] = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78};

  initial begin
    int  base, n0, d0, s0, w0;
    bit  ok;
    rst = 1'b1; start = 1'b0; force_busy = 1'b0; stuck0 = 1'b0;
    mem[0] = 32'h20010005; mem[1] = 32'h0; mem[2] = 32'h11111111; mem[3] = 32'h22222222;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic program with repeated start while busy, then start coincident with DONE.
    base = bytes.size(); n0 = nstart; d0 = ndone; s0 = stab_err;
    pulse_start();
    check("A_busy_after_start", busy, 1'b1);
    run_until_done(3000, 37, ok);
    check("A_done_seen", ok, 1'b1);
    check("A_word_count", word_count, 3'd2);
    check("A_err", err, 1'b0);
    check("A_busy_in_done", busy, 1'b0);
    pulse_start();
    check("A_done_one_cycle", done, 1'b0);
    check("A_start_in_done_ignored", busy, 1'b0);
    repeat (5) tick();
    check("A_still_idle", busy, 1'b0);
    check("A_tx_start_count", nstart - n0, 9);
    check("A_done_count", ndone - d0, 1);
    check("A_tx_data_stable", stab_err - s0, 0);
    for (int i = 0; i < 9; i++) check($sformatf("A_byte%0d", i), getb(base, i), exp_a[i]);

    // Overflow: all words nonzero, address space of four words.
    mem[0] = 32'h01020304; mem[1] = 32'h05060708; mem[2] = 32'h090A0B0C; mem[3] = 32'h0D0E0F10;
    base = bytes.size(); w0 = wrap;
    pulse_start();
    run_until_done(4000, 0, ok);
    check("B_done_seen", ok, 1'b1);
    check("B_err", err, 1'b1);
    check("B_word_count", word_count, 3'd4);
    check("B_rd_addr_end", rd_addr, 2'd3);
    check("B_no_wrap", wrap - w0, 0);
    check("B_byte_count", bytes.size() - base, 17);
    check("B_byte0", getb(base, 0), 8'hAA);
    for (int i = 1; i <= 16; i++) check($sformatf("B_byte%0d", i), getb(base, i), i);

    // Transmitter busy on ISSUE entry: no strobe until it falls, then one strobe.
    mem[0] = 32'h12345678; mem[1] = 32'h0;
    tick();
    base = bytes.size();
    force_busy = 1'b1;
    pulse_start();
    check("C_err_cleared", err, 1'b0);
    n0 = nstart;
    repeat (50) tick();
    check("C_no_start_while_busy", nstart - n0, 0);
    force_busy = 1'b0;
    tick();
    check("C_first_pulse", nstart - n0, 1);
    repeat (5) tick();
    check("C_single_pulse", nstart - n0, 1);
    run_until_done(3000, 0, ok);
    check("C_done_seen", ok, 1'b1);
    check("C_byte_count", bytes.size() - base, 9);
    for (int i = 0; i < 5; i++) check($sformatf("C_byte%0d", i), getb(base, i), exp_c[i]);

    // Reset during WAIT_LO of byte 2 of word 0, then a clean resend.
    mem[0] = 32'h20010005; mem[1] = 32'h0;
    tick();
    n0 = nstart;
    pulse_start();
    for (int i = 0; i < 500 && (nstart - n0) < 4; i++) tick();
    check("D_reached_byte2", nstart - n0, 4);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("D_abort");
    repeat (25) tick();
    base = bytes.size(); s0 = stab_err;
    pulse_start();
    run_until_done(3000, 0, ok);
    check("D_done_seen", ok, 1'b1);
    check("D_word_count", word_count, 3'd2);
    check("D_byte_count", bytes.size() - base, 9);
    check("D_tx_data_stable", stab_err - s0, 0);
    for (int i = 0; i < 9; i++) check($sformatf("D_byte%0d", i), getb(base, i), exp_a[i]);

    // Transmitter never acknowledges the first strobe.
    tick();
    stuck0 = 1'b1;
    n0 = nstart; d0 = ndone;
    pulse_start();
    for (int i = 0; i < 50 && nstart == n0; i++) tick();
    check("E_first_pulse", nstart - n0, 1);
`ifdef PROG_SENDER_WDOG_EN
    run_until_done(150, 0, ok);
    check("E_wdog_done", ok, 1'b1);
    check("E_wdog_err", err, 1'b1);
`else
    repeat (300) tick();
    check("E_still_busy", busy, 1'b1);
    check("E_no_done", ndone - d0, 0);
    check("E_no_extra_pulse", nstart - n0, 1);
`endif
    stuck0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("E_reset_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
